// File: rtl/adc128_scan_ctrl_if.sv
// ADC pin bundle for adc128_scan_ctrl.
//   ADC_CS_N : chip select, active low   (master -> ADC)
//   ADC_DIN  : serial command            (master -> ADC)
//   ADC_SCLK : serial clock, idles high  (master -> ADC)
//   ADC_DOUT : serial conversion data    (ADC -> master)
interface adc128_scan_ctrl_if;
    logic ADC_CS_N;
    logic ADC_DIN;
    logic ADC_SCLK;
    logic ADC_DOUT;

    modport master (output ADC_CS_N, output ADC_DIN, output ADC_SCLK, input ADC_DOUT);
    modport slave  (input ADC_CS_N, input ADC_DIN, input ADC_SCLK, output ADC_DOUT);
endinterface

// File: rtl/adc128_scan_ctrl.sv
// Free-running SPI scan controller for an 8-channel 12-bit serial ADC
// (ADC128S022-style). Each frame addresses the next channel and captures
// the conversion of the channel addressed in the previous frame; the latest
// result of every channel is held in a parallel register bank.
//
// Ports:
//   clock  : system clock
//   reset  : asynchronous active-low reset
//   adc    : ADC pin bundle (master side)
//   data   : data[n] = latest 12-bit result of channel n (unscanned stay 0)
//   upd    : (ADC_UPDATE_STROBE_EN) one-cycle pulse when a new word is visible
//   upd_ch : (ADC_UPDATE_STROBE_EN) channel index of the last written word
//
// Optional feature macro: ADC_UPDATE_STROBE_EN adds upd/upd_ch.
module adc128_scan_ctrl #(
    parameter int SCLK_HALF = 2,
    parameter int NUM_CH    = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    adc128_scan_ctrl_if.master    adc,
    output logic [7:0][11:0]      data
`ifdef ADC_UPDATE_STROBE_EN
    ,
    output logic                  upd,
    output logic [2:0]            upd_ch
`endif
);

    localparam int PER = 2 * SCLK_HALF;          // clocks per SCLK period
    localparam int F   = 3 + 16 * PER;           // clocks per frame
    localparam int FW  = $clog2(F);
    localparam int PW  = (PER > 1) ? $clog2(PER) : 1;
    localparam logic [FW-1:0] F_LAST = FW'(F - 1);

    logic [FW-1:0] f, f_n;      // frame counter
    logic [PW-1:0] ph, ph_n;    // clock position within the current bit
    logic [3:0]    bi, bi_n;    // bit index within the frame
    logic          act_n;       // next cycle lies in the 16-bit transfer window
    logic [2:0]    cur, nxt;
    logic [15:0]   cmd;
    logic [11:0]   sh;
    logic          cs_q, sclk_q, din_q;

    assign adc.ADC_CS_N = cs_q;
    assign adc.ADC_SCLK = sclk_q;
    assign adc.ADC_DIN  = din_q;

    // Outputs are registered from next-state values so pins line up exactly
    // with the counter value they belong to.
    always_comb begin
        nxt   = (cur == 3'(NUM_CH - 1)) ? 3'd0 : cur + 3'd1;
        cmd   = {2'b00, nxt, 11'b0};
        f_n   = (f == F_LAST) ? '0 : f + 1'b1;
        act_n = (f_n >= FW'(3));
        ph_n  = '0;
        bi_n  = '0;
        // Entering f=3 starts bit 0 at phase 0; later bits advance incrementally.
        if (act_n && f != FW'(2)) begin
            if (ph == PW'(PER - 1)) begin
                ph_n = '0;
                bi_n = bi + 4'd1;
            end else begin
                ph_n = ph + 1'b1;
                bi_n = bi;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            f      <= '0;
            ph     <= '0;
            bi     <= '0;
            cur    <= '0;
            sh     <= '0;
            data   <= '0;
            cs_q   <= 1'b1;
            sclk_q <= 1'b1;
            din_q  <= 1'b0;
`ifdef ADC_UPDATE_STROBE_EN
            upd    <= 1'b0;
            upd_ch <= '0;
`endif
        end else begin
            f      <= f_n;
            ph     <= ph_n;
            bi     <= bi_n;
            cs_q   <= (f_n == '0);
            sclk_q <= !act_n || (ph_n >= PW'(SCLK_HALF));
            // DIN only moves on entry to a low phase, so it is stable at SCLK rise.
            if (act_n && ph_n == '0)
                din_q <= cmd[4'd15 - bi_n];
            // Sample DOUT on the edge raising SCLK; first four bits are leading zeros.
            if (act_n && ph_n == PW'(SCLK_HALF) && bi_n >= 4'd4)
                sh <= {sh[10:0], adc.ADC_DOUT};
            if (f == F_LAST) begin
                data[cur] <= sh;
                cur       <= nxt;
            end
`ifdef ADC_UPDATE_STROBE_EN
            upd <= (f == F_LAST);
            if (f == F_LAST)
                upd_ch <= cur;
`endif
        end
    end

endmodule

// File: tb/tb_adc128_scan_ctrl.sv
// Bench for adc128_scan_ctrl: behavioural ADC model on the pins, frame-level
// reference computed from cycle arithmetic, random conversion values.
module tb_adc128_scan_ctrl;
    localparam int F   = 67;
    localparam int NCH = 8;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #10 clock = ~clock;

    adc128_scan_ctrl_if adc ();
    logic [7:0][11:0] data;
`ifdef ADC_UPDATE_STROBE_EN
    logic       upd;
    logic [2:0] upd_ch;
`endif

    adc128_scan_ctrl #(.SCLK_HALF(2), .NUM_CH(NCH)) dut (
        .clock (clock),
        .reset (reset),
        .adc   (adc),
        .data  (data)
`ifdef ADC_UPDATE_STROBE_EN
        ,
        .upd    (upd),
        .upd_ch (upd_ch)
`endif
    );

    // ADC model: DOUT changes after SCLK falls, 4 zeros then 12 data bits;
    // converts the channel addressed during the previous frame.
    logic        model_dout, tog_dout;
    logic [11:0] adc_val [NCH];
    logic [2:0]  conv_ch;
    logic [15:0] word, din_sr;
    logic        p_cs, p_sclk;
    int          j;

    assign adc.ADC_DOUT = reset ? model_dout : tog_dout;

    always @(negedge clock) begin
        if (!reset) begin
            conv_ch = 3'd0; din_sr = '0; model_dout = 1'b0; j = 0;
            p_cs = 1'b1; p_sclk = 1'b1; word = '0;
        end else begin
            if (p_cs && !adc.ADC_CS_N) begin
                word = {4'b0, adc_val[conv_ch]};
                j = 0;
            end
            if (!adc.ADC_CS_N && p_sclk && !adc.ADC_SCLK && j < 16) begin
                model_dout = word[15 - j];
                j++;
            end
            if (!adc.ADC_CS_N && !p_sclk && adc.ADC_SCLK)
                din_sr = {din_sr[14:0], adc.ADC_DIN};
            if (!p_cs && adc.ADC_CS_N)
                conv_ch = din_sr[13:11];
            p_cs   = adc.ADC_CS_N;
            p_sclk = adc.ADC_SCLK;
        end
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    logic [7:0][11:0] exp_data;
    logic [11:0]      served;
    int               t;

    function automatic logic [11:0] pick(input int k);
        if (k < NCH)      return 12'h5A0 + 12'(k);
        else if (k == 8)  return 12'hFFF;
        else if (k == 9)  return 12'h000;
        else              return 12'($urandom);
    endfunction

    task automatic chk_idle();
        chk("rst_cs_n", 96'(adc.ADC_CS_N), 96'd1);
        chk("rst_sclk", 96'(adc.ADC_SCLK), 96'd1);
        chk("rst_din",  96'(adc.ADC_DIN),  96'd0);
        chk("rst_data", 96'(data),         96'd0);
`ifdef ADC_UPDATE_STROBE_EN
        chk("rst_upd",    96'(upd),    96'd0);
        chk("rst_upd_ch", 96'(upd_ch), 96'd0);
`endif
    endtask

    // Check the current (negedge) cycle against the reference, then advance.
    task automatic step();
        int f, k, b;
        logic [2:0] nx;
        logic e_sclk, e_din;
        f = t % F;
        k = t / F;
        if (f == 0) begin
            if (k >= 1) exp_data[(k - 1) % NCH] = served;
            served = pick(k);
            adc_val[k % NCH] = served;
        end
        nx     = 3'((k + 1) % NCH);
        b      = (f >= 3) ? (f - 3) / 4 : 0;
        e_sclk = (f < 3) ? 1'b1 : (((f - 3) % 4) >= 2);
        e_din  = (f >= 3 && b >= 2 && b <= 4) ? nx[4 - b] : 1'b0;
        chk("cs_n", 96'(adc.ADC_CS_N), 96'(f == 0));
        chk("sclk", 96'(adc.ADC_SCLK), 96'(e_sclk));
        chk("din",  96'(adc.ADC_DIN),  96'(e_din));
        chk("data", 96'(data),         96'(exp_data));
`ifdef ADC_UPDATE_STROBE_EN
        chk("upd",    96'(upd),    96'(f == 0 && k >= 1));
        chk("upd_ch", 96'(upd_ch), (k >= 1) ? 96'((k - 1) % NCH) : 96'd0);
`endif
        @(negedge clock);
        t++;
    endtask

    initial begin
        tog_dout = 1'b0;
        exp_data = '0;
        served   = '0;
        for (int i = 0; i < NCH; i++) adc_val[i] = '0;

        // Reset held with DOUT toggling: pins idle, bank clear.
        repeat (10) begin
            @(negedge clock);
            tog_dout = 1'($urandom);
            chk_idle();
        end

        // First run, interrupted at cycle 30 of frame 3.
        reset = 1'b1;
        t = 0;
        repeat (3 * F + 30) step();
        reset = 1'b0;
        #1;
        chk_idle();
        repeat (4) begin
            @(negedge clock);
            tog_dout = 1'($urandom);
            chk_idle();
        end

        // Restart from channel 0; run past a full sweep plus extremes/random.
        reset    = 1'b1;
        t        = 0;
        exp_data = '0;
        repeat (12 * F) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Hard stop in case the run stalls.
    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule

// File: doc/adc128_scan_ctrl.md
Name: adc128_scan_ctrl

Overview:
- Free-running SPI master for an 8-channel, 12-bit serial ADC (ADC128S022-style protocol).
- Round-robins through channels 0..NUM_CH-1 and keeps the latest 12-bit conversion of every channel in a parallel register bank.
- Sits between the board ADC pins and the sampling/trigger logic, which picks channel words from `data`.

Parameters:
- SCLK_HALF, 2: system clocks per SCLK half-period. Frame length = 3 + 32*SCLK_HALF clocks (67 at default).
- NUM_CH, 8: number of channels scanned, range 1..8. Unscanned data words stay 0.

Ports:
- clock     in   1       system clock, 50 MHz nominal
- reset     in   1       asynchronous, active-low reset
- ADC_CS_N  out  1       ADC chip select, active low
- ADC_DIN   out  1       serial command to ADC (next channel address)
- ADC_SCLK  out  1       serial clock; idles high
- ADC_DOUT  in   1       serial data from ADC, MSB first
- data      out  8x12    packed array; data[n] is the latest result of channel n

Behaviour:
- Reset (reset=0, async):
  - ADC_CS_N=1, ADC_SCLK=1, ADC_DIN=0.
  - All data words = 0.
  - Frame counter f=0, current channel cur=0, shift register=0.
- All outputs are registered. "Cycle f" means outputs while the counter equals f.
- Frame counter f runs 0..F-1 (F=67 at default), then wraps to 0 forever. There is no start/enable input.
- Frame timing:
  - f=0: CS_N=1, SCLK=1 (deselect gap).
  - f=1..2: CS_N=0, SCLK=1 (CS setup).
  - f=3..F-1: CS_N=0. Bit index b=(f-3)/(2*SCLK_HALF), 0..15.
  - Within each bit, the first SCLK_HALF cycles have SCLK=0 and the next SCLK_HALF cycles have SCLK=1. This gives 16 SCLK pulses per frame.
- DIN:
  - Changes only on entry to a bit's low phase.
  - Carries bit 15-b of the command word {2'b00, nxt[2:0], 11'b0}, where nxt=(cur+1) mod NUM_CH.
  - So DIN = nxt[2] for b=2, nxt[1] for b=3, nxt[0] for b=4, and 0 for all other bits.
- DOUT sampling:
  - DOUT is sampled on the clock edge that raises SCLK (start of the high phase).
  - Bits b=0..3 (leading zeros) are discarded.
  - Bits b=4..15 are shifted into a 12-bit register, MSB first.
- End of frame (edge leaving f=F-1):
  - data[cur] <= shift register; cur <= nxt.
  - The new value is visible from the next f=0.
  - Other data words are unchanged.
- Channel association:
  - The ADC converts the channel addressed in the previous frame. After reset the ADC defaults to channel 0.
  - Frame k's result is therefore stored to channel k mod NUM_CH, and frame k addresses (k+1) mod NUM_CH.
  - A full sweep takes NUM_CH*F clocks (536 at default).
- Reset asserted mid-frame: outputs go idle immediately, data is cleared, and scanning restarts at channel 0, f=0 on release. No partial result is written.
- NUM_CH=1: address is always 0 and every frame updates data[0].

Optional Feature:
- Macro: ADC_UPDATE_STROBE_EN.
- When defined, the module adds two outputs:
  - upd (1 bit): a one-cycle pulse in the cycle data[cur] first shows its new value (f=0).
  - upd_ch (3 bits): the index of the channel just written; holds its value between pulses.
  - Both reset to 0.
- When undefined, these ports and their logic do not exist, and all other behaviour is identical.

Test Plan:
- Reset held low for 10 cycles with DOUT toggling -> CS_N=1, SCLK=1, DIN=0, all data=0 throughout.
- Release reset; record pins -> CS_N falls at cycle 1 and rises at cycle 67; exactly 16 SCLK low pulses of 2 cycles each in cycles 3..66; pattern repeats every 67 cycles.
- DIN check over the first 8 frames -> address bits (b=2..4) read 1,2,...,7,0 in order; DIN=0 in every other bit position.
- Bench ADC model (DOUT changes on SCLK falling edge, 4 zeros then 12 data bits) returns 0x5A0+n for channel n, with frame 0 being channel 0 -> data[0]=0x5A0 at cycle 67; all eight words correct after 536 cycles; values 0xFFF and 0x000 captured exactly.
- Reset pulsed low at cycle 30 of frame 3 -> immediate idle pins, data cleared; after release the first update is data[0], 67 cycles later.
- With ADC_UPDATE_STROBE_EN -> upd high exactly one cycle every 67; upd_ch sequence 0,1,...,7,0.
